rv32i_pipe_core: RTL and testbench

//  Single-clock 5-stage (IF/ID/EX/MEM/WB) RV32I integer core; successor to the two-phase pipelined core.

---
 rtl/rv32i_pipe_core.sv | 246 ++++++++++++++++++++++++
 tb/tb_rv32i_pipe_core.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_pipe_core.sv
// rv32i_pipe_core: single-clock 5-stage RV32I core (IF/ID/EX/MEM/WB)
// with forwarding, load-use interlock, EX-resolved branches, ECALL halt.
// Ports: clk, rst (synchronous, active-high)
//   imem_addr/imem_rdata : combinational-read instruction port (word addr)
//   dmem_addr/dmem_wdata/dmem_we/dmem_rdata : combinational-read data port
//   halted : sticky once ECALL retires; instret : retired-instruction count
module rv32i_pipe_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 10,
    parameter int          DMEM_AW  = 10,
    parameter bit          FWD_EN   = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic [31:0]        dmem_wdata,
    output logic               dmem_we,
    input  logic [31:0]        dmem_rdata,
    output logic               halted,
    output logic [31:0]        instret
);
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_ST   = 7'b0100011;
    localparam logic [6:0] OP_IMM  = 7'b0010011;
    localparam logic [6:0] OP_REG  = 7'b0110011;

    typedef struct packed {
        logic        v;
        logic [31:0] pc;
        logic [31:0] ir;
    } if_id_t;

    typedef struct packed {
        logic        v;
        logic [31:0] pc;
        logic [31:0] ir;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
    } id_ex_t;

    typedef struct packed {
        logic        v;
        logic        we;
        logic [4:0]  rd;
        logic        ld;
        logic        st;
        logic        ec;
        logic [31:0] res;
        logic [31:0] sd;
    } ex_mem_t;

    typedef struct packed {
        logic        v;
        logic        we;
        logic [4:0]  rd;
        logic        ec;
        logic [31:0] res;
    } mem_wb_t;

    logic [31:0] pc;
    logic [31:0] rf [0:31];
    if_id_t      if_id;
    id_ex_t      id_ex;
    ex_mem_t     ex_mem;
    mem_wb_t     mem_wb;

    // ---------------- ID ----------------
    logic [6:0]  d_op;
    logic [4:0]  d_rs1, d_rs2;
    logic        d_use1, d_use2;
    logic [31:0] d_imm, d_a, d_b;
    logic        wb_we;

    assign d_op   = if_id.ir[6:0];
    assign d_rs1  = if_id.ir[19:15];
    assign d_rs2  = if_id.ir[24:20];
    assign d_use1 = d_op inside {OP_JALR, OP_BR, OP_LD, OP_ST, OP_IMM, OP_REG};
    assign d_use2 = d_op inside {OP_BR, OP_ST, OP_REG};
    assign wb_we  = mem_wb.v && mem_wb.we && !halted;

    always_comb begin
        d_imm = '0;
        unique case (1'b1)
            d_op == OP_LUI: d_imm = {if_id.ir[31:12], 12'b0};
            d_op == OP_JAL: d_imm = {{12{if_id.ir[31]}}, if_id.ir[19:12],
                                     if_id.ir[20], if_id.ir[30:21], 1'b0};
            d_op == OP_BR:  d_imm = {{20{if_id.ir[31]}}, if_id.ir[7],
                                     if_id.ir[30:25], if_id.ir[11:8], 1'b0};
            d_op == OP_ST:  d_imm = {{21{if_id.ir[31]}}, if_id.ir[30:25],
                                     if_id.ir[11:7]};
            default:        d_imm = {{21{if_id.ir[31]}}, if_id.ir[30:20]};
        endcase
    end

    // Write-before-read: the value retiring this cycle bypasses the array.
    always_comb begin
        d_a = rf[d_rs1];
        d_b = rf[d_rs2];
        if (wb_we && mem_wb.rd == d_rs1) d_a = mem_wb.res;
        if (wb_we && mem_wb.rd == d_rs2) d_b = mem_wb.res;
        if (d_rs1 == 5'd0) d_a = '0;
        if (d_rs2 == 5'd0) d_b = '0;
    end

    // ---------------- EX ----------------
    logic [6:0]  e_op;
    logic [2:0]  e_f3;
    logic [4:0]  e_rd, e_rs1, e_rs2;
    logic [31:0] x_a, x_b, e_b, e_alu, e_addr, e_res, e_tgt;
    logic [4:0]  e_sh;
    logic        e_take, e_we, e_ec, redirect;
    logic        m_e, m_m, stall, stop;

    assign e_op  = id_ex.ir[6:0];
    assign e_f3  = id_ex.ir[14:12];
    assign e_rd  = id_ex.ir[11:7];
    assign e_rs1 = id_ex.ir[19:15];
    assign e_rs2 = id_ex.ir[24:20];
    assign e_ec  = id_ex.ir == 32'h0000_0073;
    assign e_we  = id_ex.v && e_rd != 5'd0 &&
                   (e_op inside {OP_LUI, OP_JAL, OP_JALR, OP_LD, OP_IMM, OP_REG});

    // EX/MEM result beats MEM/WB result beats the value read in ID.
    always_comb begin
        x_a = id_ex.a;
        x_b = id_ex.b;
        if (FWD_EN) begin
            if (mem_wb.v && mem_wb.we && mem_wb.rd == e_rs1) x_a = mem_wb.res;
            if (mem_wb.v && mem_wb.we && mem_wb.rd == e_rs2) x_b = mem_wb.res;
            if (ex_mem.v && ex_mem.we && ex_mem.rd == e_rs1) x_a = ex_mem.res;
            if (ex_mem.v && ex_mem.we && ex_mem.rd == e_rs2) x_b = ex_mem.res;
        end
    end

    assign e_b    = (e_op == OP_REG) ? x_b : id_ex.imm;
    assign e_sh   = e_b[4:0];
    assign e_addr = x_a + id_ex.imm;

    always_comb begin
        e_alu = '0;
        case (e_f3)
            3'd0: e_alu = (e_op == OP_REG && id_ex.ir[30]) ? x_a - e_b : x_a + e_b;
            3'd1: e_alu = x_a << e_sh;
            3'd2: e_alu = {31'b0, $signed(x_a) < $signed(e_b)};
            3'd3: e_alu = {31'b0, x_a < e_b};
            3'd4: e_alu = x_a ^ e_b;
            3'd5: e_alu = id_ex.ir[30] ? 32'($signed(x_a) >>> e_sh) : x_a >> e_sh;
            3'd6: e_alu = x_a | e_b;
            default: e_alu = x_a & e_b;
        endcase
    end

    always_comb begin
        e_take = 1'b0;
        case (e_f3)
            3'd0: e_take = x_a == x_b;
            3'd1: e_take = x_a != x_b;
            3'd4: e_take = $signed(x_a) < $signed(x_b);
            3'd5: e_take = $signed(x_a) >= $signed(x_b);
            3'd6: e_take = x_a < x_b;
            3'd7: e_take = x_a >= x_b;
            default: e_take = 1'b0;
        endcase
    end

    always_comb begin
        e_res = e_alu;
        unique case (1'b1)
            e_op == OP_LUI:                    e_res = id_ex.imm;
            e_op == OP_JAL || e_op == OP_JALR: e_res = id_ex.pc + 32'd4;
            e_op == OP_LD || e_op == OP_ST:    e_res = e_addr;
            default:                           e_res = e_alu;
        endcase
    end

    assign redirect = id_ex.v && (e_op == OP_JAL || e_op == OP_JALR ||
                                  (e_op == OP_BR && e_take));
    assign e_tgt = (e_op == OP_JALR) ? {e_addr[31:1], 1'b0} : id_ex.pc + id_ex.imm;

    // Source matches against producers still in EX or MEM.
    assign m_e = e_we && ((d_use1 && d_rs1 == e_rd) || (d_use2 && d_rs2 == e_rd));
    assign m_m = ex_mem.v && ex_mem.we &&
                 ((d_use1 && d_rs1 == ex_mem.rd) || (d_use2 && d_rs2 == ex_mem.rd));
    assign stall = if_id.v && (FWD_EN ? (m_e && e_op == OP_LD) : (m_e || m_m));

    // ---------------- MEM / outputs ----------------
    // stop covers the cycle the ECALL retires: younger work must not commit.
    assign stop       = halted || (mem_wb.v && mem_wb.ec);
    assign imem_addr  = pc[IMEM_AW+1:2];
    assign dmem_addr  = ex_mem.res[DMEM_AW+1:2];
    assign dmem_wdata = ex_mem.sd;
    assign dmem_we    = ex_mem.v && ex_mem.st && !stop && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc      <= RESET_PC;
            if_id   <= '0;
            id_ex   <= '0;
            ex_mem  <= '0;
            mem_wb  <= '0;
            halted  <= 1'b0;
            instret <= '0;
        end else if (!halted) begin
            if (mem_wb.v) instret <= instret + 32'd1;
            if (mem_wb.v && mem_wb.ec) halted <= 1'b1;
            if (!stop) begin
                mem_wb.v   <= ex_mem.v;
                mem_wb.we  <= ex_mem.we;
                mem_wb.rd  <= ex_mem.rd;
                mem_wb.ec  <= ex_mem.ec;
                mem_wb.res <= ex_mem.ld ? dmem_rdata : ex_mem.res;
                ex_mem.v   <= id_ex.v;
                ex_mem.we  <= e_we;
                ex_mem.rd  <= e_rd;
                ex_mem.ld  <= id_ex.v && e_op == OP_LD;
                ex_mem.st  <= id_ex.v && e_op == OP_ST;
                ex_mem.ec  <= id_ex.v && e_ec;
                ex_mem.res <= e_res;
                ex_mem.sd  <= x_b;
                if (redirect) begin
                    pc    <= e_tgt;
                    if_id <= '0;
                    id_ex <= '0;
                end else if (stall) begin
                    id_ex <= '0;
                end else begin
                    pc    <= pc + 32'd4;
                    if_id <= '{v: 1'b1, pc: pc, ir: imem_rdata};
                    id_ex <= '{v: if_id.v, pc: if_id.pc, ir: if_id.ir,
                               a: d_a, b: d_b, imm: d_imm};
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wb_we) rf[mem_wb.rd] <= mem_wb.res;
    end
endmodule

// File: tb/tb_rv32i_pipe_core.sv
// tb_rv32i_pipe_core: directed programs on two cores (forwarding on/off)
// sharing one instruction memory; stores are logged per core.
module tb_rv32i_pipe_core;
    localparam logic [31:0] ECALL = 32'h0000_0073;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] imem [0:63];
    logic [31:0] dinit [0:63];

    logic [9:0]  ia1, da1, ia0, da0;
    logic [31:0] ir1, ir0, wd1, wd0, dr1, dr0, ins1, ins0;
    logic        we1, we0, h1, h0;

    assign ir1 = imem[ia1[5:0]];
    assign ir0 = imem[ia0[5:0]];
    assign dr1 = dinit[da1[5:0]];
    assign dr0 = dinit[da0[5:0]];

    rv32i_pipe_core dut (
        .clk(clk), .rst(rst),
        .imem_addr(ia1), .imem_rdata(ir1),
        .dmem_addr(da1), .dmem_wdata(wd1), .dmem_we(we1),
        .dmem_rdata(dr1), .halted(h1), .instret(ins1)
    );

    rv32i_pipe_core #(.FWD_EN(1'b0)) dut0 (
        .clk(clk), .rst(rst),
        .imem_addr(ia0), .imem_rdata(ir0),
        .dmem_addr(da0), .dmem_wdata(wd0), .dmem_we(we0),
        .dmem_rdata(dr0), .halted(h0), .instret(ins0)
    );

    int vec = 0;
    int err = 0;
    int sn1 = 0;
    int sn0 = 0;
    logic [9:0]  sa1 [0:63];
    logic [31:0] sd1 [0:63];
    logic [31:0] sd0 [0:63];
    logic [31:0] tr  [0:63];

    always @(negedge clk) begin
        if (we1) begin
            sa1[sn1[5:0]] <= da1;
            sd1[sn1[5:0]] <= wd1;
            sn1 <= sn1 + 1;
        end
        if (we0) begin
            sd0[sn0[5:0]] <= wd0;
            sn0 <= sn0 + 1;
        end
    end

    function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd,
                                          logic [6:0] op);
        logic [31:0] iv;
        iv = imm;
        return {iv[11:0], 5'(rs1), 3'(f3), 5'(rd), op};
    endfunction

    function automatic logic [31:0] addi(int rd, int rs1, int imm);
        return enc_i(imm, rs1, 0, rd, 7'b0010011);
    endfunction

    function automatic logic [31:0] lw(int rd, int rs1, int imm);
        return enc_i(imm, rs1, 2, rd, 7'b0000011);
    endfunction

    function automatic logic [31:0] rop(int f7, int rd, int rs1, int rs2);
        return {7'(f7), 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'b0110011};
    endfunction

    function automatic logic [31:0] sw(int rs2, int rs1, int imm);
        logic [31:0] iv;
        iv = imm;
        return {iv[11:5], 5'(rs2), 5'(rs1), 3'b010, iv[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] br(int f3, int rs1, int rs2, int imm);
        logic [31:0] iv;
        iv = imm;
        return {iv[12], iv[10:5], 5'(rs2), 5'(rs1), 3'(f3),
                iv[4:1], iv[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] jal(int rd, int imm);
        logic [31:0] iv;
        iv = imm;
        return {iv[20], iv[10:1], iv[11], iv[19:12], 5'(rd), 7'b1101111};
    endfunction

    task automatic clear_imem();
        for (int i = 0; i < 64; i++) imem[i] = NOP;
    endtask

    // Reset both cores, then count rising edges until each is halted.
    task automatic run_prog(output int n1, output int n0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        n1 = -1;
        n0 = -1;
        for (int c = 1; c <= 300; c++) begin
            @(posedge clk);
            #1;
            if (c < 64) tr[c] = ins1;
            if (n1 < 0 && h1) n1 = c;
            if (n0 < 0 && h0) n0 = c;
            if (n1 >= 0 && n0 >= 0) break;
        end
        vec++;
        if (n1 < 0 || n0 < 0) begin
            err++;
            $display("FAIL run_timeout: halt edges %0d/%0d, need both >= 0", n1, n0);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vec++;
        if (ia1 !== 10'd0) begin
            err++; $display("FAIL reset_pc: got %0d want 0", ia1);
        end
        vec++;
        if (we1 !== 1'b0 || we0 !== 1'b0) begin
            err++; $display("FAIL reset_we: got %b/%b want 0", we1, we0);
        end
        vec++;
        if (h1 !== 1'b0 || h0 !== 1'b0) begin
            err++; $display("FAIL reset_halted: got %b/%b want 0", h1, h0);
        end
        vec++;
        if (ins1 !== 32'd0) begin
            err++; $display("FAIL reset_instret: got %0d want 0", ins1);
        end
    endtask

    task automatic test_forwarding();
        int n1, n0, b1, b0;
        clear_imem();
        imem[0] = addi(1, 0, 5);
        imem[1] = rop(0, 2, 1, 1);
        imem[2] = rop(32, 3, 2, 1);
        imem[3] = sw(2, 0, 0);
        imem[4] = sw(3, 0, 4);
        imem[5] = ECALL;
        b1 = sn1;
        b0 = sn0;
        run_prog(n1, n0);
        vec++;
        if (n1 != 10) begin
            err++; $display("FAIL fwd_cycles: got %0d want 10", n1);
        end
        vec++;
        if (tr[4] !== 32'd0 || tr[5] !== 32'd1 || tr[6] !== 32'd2) begin
            err++;
            $display("FAIL fwd_retire: got %0d,%0d,%0d want 0,1,2",
                     tr[4], tr[5], tr[6]);
        end
        vec++;
        if (ins1 !== 32'd6) begin
            err++; $display("FAIL fwd_instret: got %0d want 6", ins1);
        end
        vec++;
        if (sn1 - b1 != 2 || sd1[b1] !== 32'd10 || sa1[b1] !== 10'd0) begin
            err++;
            $display("FAIL fwd_x2: got n=%0d a=%0d d=%0d want 2,0,10",
                     sn1 - b1, sa1[b1], sd1[b1]);
        end
        vec++;
        if (sd1[b1+1] !== 32'd5 || sa1[b1+1] !== 10'd1) begin
            err++;
            $display("FAIL fwd_x3: got a=%0d d=%0d want 1,5", sa1[b1+1], sd1[b1+1]);
        end
        vec++;
        if (sd0[b0] !== 32'd10 || sd0[b0+1] !== 32'd5 || n0 <= n1) begin
            err++;
            $display("FAIL nofwd_fwd: got %0d,%0d cyc %0d want 10,5 cyc>%0d",
                     sd0[b0], sd0[b0+1], n0, n1);
        end
    endtask

    task automatic test_load_use();
        int n1, n0, b1, b0;
        clear_imem();
        imem[0] = lw(5, 0, 16);
        imem[1] = addi(6, 5, 1);
        imem[2] = sw(6, 0, 8);
        imem[3] = ECALL;
        b1 = sn1;
        b0 = sn0;
        run_prog(n1, n0);
        vec++;
        if (n1 != 9) begin
            err++; $display("FAIL lu_cycles: got %0d want 9", n1);
        end
        vec++;
        if (sd1[b1] !== 32'h1235 || sa1[b1] !== 10'd2 || sn1 - b1 != 1) begin
            err++;
            $display("FAIL lu_x6: got a=%0d d=%h want 2,1235", sa1[b1], sd1[b1]);
        end
        vec++;
        if (ins1 !== 32'd4 || ins0 !== 32'd4) begin
            err++; $display("FAIL lu_instret: got %0d/%0d want 4", ins1, ins0);
        end
        vec++;
        if (n0 != 12) begin
            err++; $display("FAIL lu_nofwd_cycles: got %0d want 12", n0);
        end
        vec++;
        if (sd0[b0] !== 32'h1235 || sn0 - b0 != 1) begin
            err++; $display("FAIL lu_nofwd_x6: got %h want 1235", sd0[b0]);
        end
    endtask

    task automatic test_branch();
        int n1, n0, b1;
        clear_imem();
        imem[0] = addi(1, 0, 7);
        imem[1] = addi(2, 0, 7);
        imem[2] = addi(9, 0, 0);
        imem[3] = br(0, 1, 2, 12);
        imem[4] = addi(9, 0, 1);
        imem[5] = addi(9, 0, 1);
        imem[6] = sw(9, 0, 0);
        imem[7] = ECALL;
        b1 = sn1;
        run_prog(n1, n0);
        vec++;
        if (n1 != 12) begin
            err++; $display("FAIL beq_cycles: got %0d want 12", n1);
        end
        vec++;
        if (sd1[b1] !== 32'd0 || sn1 - b1 != 1) begin
            err++; $display("FAIL beq_x9: got %0d want 0", sd1[b1]);
        end
        vec++;
        if (ins1 !== 32'd6) begin
            err++; $display("FAIL beq_instret: got %0d want 6", ins1);
        end
        clear_imem();
        imem[0] = addi(1, 0, -1);
        imem[1] = addi(2, 0, 1);
        imem[2] = addi(9, 0, 0);
        imem[3] = br(6, 1, 2, 8);
        imem[4] = addi(9, 9, 1);
        imem[5] = br(4, 1, 2, 8);
        imem[6] = addi(9, 9, 16);
        imem[7] = sw(9, 0, 0);
        imem[8] = ECALL;
        b1 = sn1;
        run_prog(n1, n0);
        vec++;
        if (sd1[b1] !== 32'd1 || sn1 - b1 != 1) begin
            err++; $display("FAIL blt_bltu_x9: got %0d want 1", sd1[b1]);
        end
        vec++;
        if (n1 != 14 || ins1 !== 32'd8) begin
            err++;
            $display("FAIL blt_timing: got cyc %0d ret %0d want 14,8", n1, ins1);
        end
    endtask

    task automatic test_jump_halt();
        int n1, n0, b1, b0;
        clear_imem();
        imem[0] = jal(0, 32);
        for (int i = 1; i < 8; i++) imem[i] = addi(9, 0, 85);
        imem[8]  = jal(1, 8);
        imem[9]  = addi(9, 0, 85);
        imem[10] = sw(1, 0, 0);
        imem[11] = ECALL;
        imem[12] = sw(0, 0, 4);
        imem[13] = sw(0, 0, 8);
        b1 = sn1;
        b0 = sn0;
        run_prog(n1, n0);
        vec++;
        if (n1 != 12) begin
            err++; $display("FAIL jal_cycles: got %0d want 12", n1);
        end
        vec++;
        if (sd1[b1] !== 32'h24 || sa1[b1] !== 10'd0) begin
            err++; $display("FAIL jal_x1: got %h want 24", sd1[b1]);
        end
        vec++;
        if (ins1 !== 32'd4) begin
            err++; $display("FAIL halt_instret: got %0d want 4", ins1);
        end
        repeat (5) @(posedge clk);
        #1;
        vec++;
        if (sn1 - b1 != 1 || sn0 - b0 != 1) begin
            err++;
            $display("FAIL halt_no_store: got %0d/%0d stores want 1", sn1 - b1, sn0 - b0);
        end
        vec++;
        if (ins1 !== 32'd4 || h1 !== 1'b1) begin
            err++; $display("FAIL halt_frozen: got ret %0d h %b want 4,1", ins1, h1);
        end
        vec++;
        if (ia1 !== 10'd15) begin
            err++; $display("FAIL halt_pc: got %0d want 15", ia1);
        end
    endtask

    task automatic test_mid_reset();
        int n, b1;
        clear_imem();
        imem[0] = addi(1, 0, 3);
        imem[1] = sw(1, 0, 12);
        imem[2] = ECALL;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        vec++;
        if (h1 !== 1'b0) begin
            err++; $display("FAIL rst_clears_halt: got %b want 0", h1);
        end
        b1 = sn1;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        vec++;
        if (we1 !== 1'b0) begin
            err++; $display("FAIL midrst_we: got %b want 0", we1);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        vec++;
        if (ia1 !== 10'd0 || ins1 !== 32'd0 || sn1 != b1) begin
            err++;
            $display("FAIL midrst_state: got pc %0d ret %0d st %0d want 0,0,0",
                     ia1, ins1, sn1 - b1);
        end
        n = -1;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk);
            #1;
            if (h1) begin
                n = c;
                break;
            end
        end
        vec++;
        if (n != 7 || ins1 !== 32'd3) begin
            err++; $display("FAIL midrst_rerun: got cyc %0d ret %0d want 7,3", n, ins1);
        end
        vec++;
        if (sn1 - b1 != 1 || sd1[b1] !== 32'd3 || sa1[b1] !== 10'd3) begin
            err++;
            $display("FAIL midrst_store: got n=%0d a=%0d d=%0d want 1,3,3",
                     sn1 - b1, sa1[b1], sd1[b1]);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) dinit[i] = 32'd0;
        dinit[4] = 32'h0000_1234;
        clear_imem();
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch();
        test_jump_halt();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule
